// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period measurement with loss-of-signal timeout
module pwm_capture #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pwm_input,
    output logic [COUNTER_WIDTH-1:0] high_count,
    output logic [COUNTER_WIDTH-1:0] period_count,
    output logic                     measure_valid,
    output logic                     signal_lost,
    output logic                     stuck_level
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    state_t                   state;
    logic                     sync1;
    logic                     pwm_s;
    logic                     pwm_prev;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] high_tmp;
    logic [COUNTER_WIDTH-1:0] cnt_inc;
    logic                     rise;
    logic                     fall;

    // Two flops bring the line into the clock domain, a third gives the previous level for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_prev <= 1'b0;
        end else begin
            sync1    <= pwm_input;
            pwm_s    <= sync1;
            pwm_prev <= pwm_s;
        end
    end

    assign rise    = pwm_s & ~pwm_prev;
    assign fall    = ~pwm_s & pwm_prev;
    // The counter sticks at all-ones so a dead line never aliases to a short period
    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

    // Measurement state machine; all outputs are registered here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= WAIT_RISE;
            cnt           <= '0;
            high_tmp      <= '0;
            high_count    <= '0;
            period_count  <= '0;
            measure_valid <= 1'b0;
            signal_lost   <= 1'b0;
            stuck_level   <= 1'b0;
        end else begin
            measure_valid <= 1'b0;
            if (signal_lost) begin
                stuck_level <= pwm_s;
            end

            case (state)
                WAIT_RISE: begin
                    // First rise after reset or loss only starts a period; nothing complete to report yet
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= MEAS_HIGH;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            signal_lost <= 1'b1;
                            stuck_level <= pwm_s;
                        end
                    end
                end

                MEAS_HIGH: begin
                    // An edge on the saturating cycle is still a valid edge, so it is tested before the timeout
                    if (fall) begin
                        high_tmp <= cnt;
                        cnt      <= cnt_inc;
                        state    <= MEAS_LOW;
                    end else if (cnt == CNT_MAX) begin
                        signal_lost <= 1'b1;
                        stuck_level <= pwm_s;
                        state       <= WAIT_RISE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                MEAS_LOW: begin
                    if (rise) begin
                        high_count    <= high_tmp;
                        period_count  <= cnt;
                        measure_valid <= 1'b1;
                        signal_lost   <= 1'b0;
                        cnt           <= CNT_ONE;
                        state         <= MEAS_HIGH;
                    end else if (cnt == CNT_MAX) begin
                        signal_lost <= 1'b1;
                        stuck_level <= pwm_s;
                        state       <= WAIT_RISE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state <= WAIT_RISE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture at widths 16 and 10
module tb_pwm_capture;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] p;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pwm16 = 1'b0;
    logic        pwm10 = 1'b0;
    logic [15:0] hc16;
    logic [15:0] pc16;
    logic        mv16;
    logic        lost16;
    logic        stuck16;
    logic [9:0]  hc10;
    logic [9:0]  pc10;
    logic        mv10;
    logic        lost10;
    logic        stuck10;

    int   errors = 0;
    int   checks = 0;
    exp_t q16[$];
    exp_t q10[$];
    int   prev_h[2];
    int   prev_l[2];
    bit   have_prev[2];
    int   cyc = 0;
    int   last16 = 0;
    bit   have_last16 = 1'b0;

    pwm_capture #(.COUNTER_WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .pwm_input(pwm16),
        .high_count(hc16), .period_count(pc16), .measure_valid(mv16),
        .signal_lost(lost16), .stuck_level(stuck16)
    );

    pwm_capture #(.COUNTER_WIDTH(10)) dut10 (
        .clock(clock), .reset(reset), .pwm_input(pwm10),
        .high_count(hc10), .period_count(pc10), .measure_valid(mv10),
        .signal_lost(lost10), .stuck_level(stuck10)
    );

    always #5 clock = ~clock;

    // Width-16 monitor: pops one expectation per valid and checks spacing against the measured period
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            have_last16 = 1'b0;
        end else if (mv16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid16 got high=%0d period=%0d, required no valid", hc16, pc16);
            end else begin
                e = q16.pop_front();
                if (hc16 !== e.h || pc16 !== e.p) begin
                    errors++;
                    $display("FAIL counts16 got high=%0d period=%0d, required high=%0d period=%0d", hc16, pc16, e.h, e.p);
                end
                if (have_last16) begin
                    checks++;
                    if (cyc - last16 != int'(e.p)) begin
                        errors++;
                        $display("FAIL interval16 got %0d clocks, required %0d", cyc - last16, e.p);
                    end
                end
            end
            have_last16 = 1'b1;
            last16 = cyc;
        end
        cyc++;
    end

    // Width-10 monitor
    always @(negedge clock) begin
        exp_t e;
        if (!reset && mv10) begin
            checks++;
            if (q10.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid10 got high=%0d period=%0d, required no valid", hc10, pc10);
            end else begin
                e = q10.pop_front();
                if ({6'd0, hc10} !== e.h || {6'd0, pc10} !== e.p) begin
                    errors++;
                    $display("FAIL counts10 got high=%0d period=%0d, required high=%0d period=%0d", hc10, pc10, e.h, e.p);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic set_pwm(input int sel, input logic v);
        if (sel == 0) pwm16 = v;
        else pwm10 = v;
    endtask

    task automatic push(input int sel, input int h, input int p);
        exp_t e;
        e.h = 16'(h);
        e.p = 16'(p);
        if (sel == 0) q16.push_back(e);
        else q10.push_back(e);
    endtask

    // The rise that starts this period completes the previous one, so its expectation is queued here
    task automatic drive_period(input int sel, input int h, input int l);
        if (have_prev[sel]) push(sel, prev_h[sel], prev_h[sel] + prev_l[sel]);
        set_pwm(sel, 1'b1);
        repeat (h) @(negedge clock);
        set_pwm(sel, 1'b0);
        repeat (l) @(negedge clock);
        prev_h[sel]    = h;
        prev_l[sel]    = l;
        have_prev[sel] = 1'b1;
    endtask

    task automatic finish_train(input int sel);
        if (have_prev[sel]) push(sel, prev_h[sel], prev_h[sel] + prev_l[sel]);
        set_pwm(sel, 1'b1);
        repeat (4) @(negedge clock);
        set_pwm(sel, 1'b0);
        repeat (8) @(negedge clock);
        have_prev[sel] = 1'b0;
    endtask

    task automatic check_drained(input int sel, input string name);
        int n;
        n = (sel == 0) ? q16.size() : q10.size();
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL %s_drained got %0d pending valids, required 0", name, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pwm16 = 1'b0;
        pwm10 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        q16.delete();
        q10.delete();
        have_prev[0] = 1'b0;
        have_prev[1] = 1'b0;
    endtask

    task automatic wait_lost10(output int n);
        n = 0;
        while (lost10 !== 1'b1 && n < 1200) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({hc16, pc16, mv16, lost16, stuck16} !== 35'd0) begin
            errors++;
            $display("FAIL reset16 got hc=%0d pc=%0d mv=%0b lost=%0b stuck=%0b, required all 0", hc16, pc16, mv16, lost16, stuck16);
        end
        checks++;
        if ({hc10, pc10, mv10, lost10, stuck10} !== 23'd0) begin
            errors++;
            $display("FAIL reset10 got hc=%0d pc=%0d mv=%0b lost=%0b stuck=%0b, required all 0", hc10, pc10, mv10, lost10, stuck10);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        repeat (4) drive_period(0, 126, 384);
        finish_train(0);
        check_drained(0, "basic");
    endtask

    task automatic test_per_period();
        do_reset();
        repeat (2) drive_period(0, 255, 255);
        repeat (2) drive_period(0, 382, 128);
        finish_train(0);
        check_drained(0, "per_period");
    endtask

    task automatic test_min_period();
        do_reset();
        repeat (8) drive_period(0, 1, 1);
        finish_train(0);
        check_drained(0, "min_period");
    endtask

    task automatic test_reset_mid_low();
        do_reset();
        repeat (2) drive_period(0, 20, 40);
        push(0, 20, 60);
        pwm16 = 1'b1;
        repeat (10) @(negedge clock);
        pwm16 = 1'b0;
        repeat (15) @(negedge clock);
        check_drained(0, "pre_reset");
        reset = 1'b1;
        #1;
        checks++;
        if ({hc16, pc16, mv16, lost16, stuck16} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset got hc=%0d pc=%0d mv=%0b lost=%0b stuck=%0b, required all 0", hc16, pc16, mv16, lost16, stuck16);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        have_prev[0] = 1'b0;
        q16.delete();
        repeat (2) drive_period(0, 20, 40);
        finish_train(0);
        check_drained(0, "post_reset");
    endtask

    task automatic test_idle_low();
        int n;
        do_reset();
        wait_lost10(n);
        // cnt climbs from 0 one per clock and the flag is set on the edge it becomes 1023
        checks++;
        if (n != 1023) begin
            errors++;
            $display("FAIL idle_timeout got %0d clocks, required 1023", n);
        end
        checks++;
        if (stuck10 !== 1'b0 || hc10 !== 10'd0 || pc10 !== 10'd0) begin
            errors++;
            $display("FAIL idle_state got stuck=%0b hc=%0d pc=%0d, required stuck=0 hc=0 pc=0", stuck10, hc10, pc10);
        end
        repeat (20) @(negedge clock);
        check_drained(1, "idle");
    endtask

    task automatic test_stuck_high();
        int n;
        do_reset();
        repeat (3) drive_period(1, 10, 20);
        checks++;
        if (lost10 !== 1'b0) begin
            errors++;
            $display("FAIL lost_before_hold got %0b, required 0", lost10);
        end
        push(1, 10, 30);
        have_prev[1] = 1'b0;
        pwm10 = 1'b1;
        wait_lost10(n);
        // rise is acted on 3 edges after the input change (cnt=1), cnt hits 1023 at edge 1025, timeout at 1026
        checks++;
        if (n != 1026) begin
            errors++;
            $display("FAIL high_timeout got %0d clocks, required 1026", n);
        end
        checks++;
        if (stuck10 !== 1'b1 || hc10 !== 10'd10 || pc10 !== 10'd30) begin
            errors++;
            $display("FAIL hold_state got stuck=%0b hc=%0d pc=%0d, required stuck=1 hc=10 pc=30", stuck10, hc10, pc10);
        end
        repeat (5) @(negedge clock);
        pwm10 = 1'b0;
        repeat (20) @(negedge clock);
        drive_period(1, 10, 20);
        checks++;
        if (lost10 !== 1'b1) begin
            errors++;
            $display("FAIL lost_after_first_rise got %0b, required 1", lost10);
        end
        drive_period(1, 10, 20);
        finish_train(1);
        checks++;
        if (lost10 !== 1'b0) begin
            errors++;
            $display("FAIL lost_cleared got %0b, required 0", lost10);
        end
        check_drained(1, "stuck_high");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_per_period();
        test_min_period();
        test_reset_mid_low();
        test_idle_low();
        test_stuck_high();
        check_drained(0, "final16");
        check_drained(1, "final10");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
